// File: rtl/mips_mem_pkg.sv
// Shared encodings for the load/store sequencer in front of the data RAM.
package mips_mem_pkg;

  typedef enum logic [2:0] {
    MEM_LB  = 3'd0,
    MEM_LBU = 3'd1,
    MEM_LH  = 3'd2,
    MEM_LHU = 3'd3,
    MEM_LW  = 3'd4,
    MEM_SB  = 3'd5,
    MEM_SH  = 3'd6,
    MEM_SW  = 3'd7
  } mem_op_e;

  localparam logic [1:0] MASK_BYTE = 2'b00;
  localparam logic [1:0] MASK_HALF = 2'b01;
  localparam logic [1:0] MASK_WORD = 2'b10;

  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2,
    ST_EXC    = 2'd3
  } mau_state_e;

endpackage

// File: rtl/mem_op_decode.sv
// Combinational decode of a memory op: direction, access size, sign
// extension, and natural-alignment check of the effective address.
module mem_op_decode
  import mips_mem_pkg::*;
(
  input  logic [2:0] op_i,
  input  logic [1:0] ea_lo_i,
  output logic       is_store_o,
  output logic [1:0] mask_o,
  output logic       signed_ext_o,
  output logic       misaligned_o
);

  // Op table lookup; alignment depends only on the access size.
  always_comb begin
    is_store_o   = 1'b0;
    mask_o       = MASK_BYTE;
    signed_ext_o = 1'b0;
    case (op_i)
      MEM_LB:  begin mask_o = MASK_BYTE; signed_ext_o = 1'b1; end
      MEM_LBU: begin mask_o = MASK_BYTE; end
      MEM_LH:  begin mask_o = MASK_HALF; signed_ext_o = 1'b1; end
      MEM_LHU: begin mask_o = MASK_HALF; end
      MEM_LW:  begin mask_o = MASK_WORD; end
      MEM_SB:  begin mask_o = MASK_BYTE; is_store_o = 1'b1; end
      MEM_SH:  begin mask_o = MASK_HALF; is_store_o = 1'b1; end
      MEM_SW:  begin mask_o = MASK_WORD; is_store_o = 1'b1; end
      default: begin mask_o = MASK_BYTE; end
    endcase
    misaligned_o = ((mask_o == MASK_HALF) && ea_lo_i[0]) ||
                   ((mask_o == MASK_WORD) && (ea_lo_i != 2'b00));
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store sequencer between the multicycle control FSM and the data RAM.
//
//   state  | meaning
//   IDLE   | ready for a request; address formed and checked on accept
//   ACCESS | RAM port driven; store writes once, load waits then captures
//   DONE   | one-cycle completion pulse
//   EXC    | one-cycle completion pulse flagged as an address error
module mem_access_unit
  import mips_mem_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 1,
  parameter int unsigned ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_op,
  input  logic [31:0]       req_base,
  input  logic [15:0]       req_offset,
  input  logic [31:0]       req_wdata,
  input  logic              flush,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_exc,
  output logic [4:0]        resp_exc_code,
  output logic [ADDR_W-1:0] resp_badvaddr,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [1:0]        ram_mask,
  output logic              ram_signed_ext,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);

  localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

  mau_state_e        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              is_store_q;
  logic [ADDR_W-1:0] ram_addr_q;
  logic [1:0]        ram_mask_q;
  logic              ram_sext_q;
  logic [31:0]       ram_wdata_q;
  logic [31:0]       rdata_q;
  logic [4:0]        exc_code_q;
  logic [ADDR_W-1:0] badvaddr_q;

  logic [31:0]       ea_full;
  logic [ADDR_W-1:0] ea;
  logic              dec_is_store;
  logic [1:0]        dec_mask;
  logic              dec_sext;
  logic              dec_misaligned;
  logic              accept;
  logic              capture;

  // Wraps mod 2^32; no overflow trap on address arithmetic.
  assign ea_full = req_base + {{16{req_offset[15]}}, req_offset};
  assign ea      = ea_full[ADDR_W-1:0];

  mem_op_decode u_decode (
    .op_i         (req_op),
    .ea_lo_i      (ea[1:0]),
    .is_store_o   (dec_is_store),
    .mask_o       (dec_mask),
    .signed_ext_o (dec_sext),
    .misaligned_o (dec_misaligned)
  );

  assign accept = (state_q == ST_IDLE) && req_valid;

  // Next-state, counter and load-capture decisions.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          if (dec_misaligned) begin
            state_d = ST_EXC;
          end else begin
            state_d = ST_ACCESS;
            cnt_d   = dec_is_store ? 4'd0 : CNT_INIT;
          end
        end
      end
      ST_ACCESS: begin
        if (flush) begin
          state_d = ST_IDLE;
          cnt_d   = 4'd0;
        end else if (is_store_q) begin
          state_d = ST_DONE;
        end else if (cnt_q == 4'd0) begin
          state_d = ST_DONE;
          capture = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_DONE, ST_EXC: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // Flush suppresses the write and the completion pulse in the same cycle.
  always_comb begin
    req_ready      = (state_q == ST_IDLE);
    resp_valid     = ((state_q == ST_DONE) || (state_q == ST_EXC)) && !flush;
    resp_exc       = (state_q == ST_EXC) && !flush;
    ram_we         = (state_q == ST_ACCESS) && is_store_q && !flush;
    resp_rdata     = rdata_q;
    resp_exc_code  = exc_code_q;
    resp_badvaddr  = badvaddr_q;
    ram_addr       = ram_addr_q;
    ram_mask       = ram_mask_q;
    ram_signed_ext = ram_sext_q;
    ram_wdata      = ram_wdata_q;
  end

  // State, RAM-port shadow registers, MDR and exception capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      is_store_q  <= 1'b0;
      ram_addr_q  <= '0;
      ram_mask_q  <= 2'b00;
      ram_sext_q  <= 1'b0;
      ram_wdata_q <= 32'd0;
      rdata_q     <= 32'd0;
      exc_code_q  <= 5'd0;
      badvaddr_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept && !dec_misaligned) begin
        is_store_q  <= dec_is_store;
        ram_addr_q  <= ea;
        ram_mask_q  <= dec_mask;
        ram_sext_q  <= dec_sext;
        ram_wdata_q <= req_wdata;
      end
      if (accept && dec_misaligned) begin
        exc_code_q <= dec_is_store ? EXC_ADES : EXC_ADEL;
        badvaddr_q <= ea;
      end
      if (capture) begin
        rdata_q <= ram_rdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: one instance with a single-cycle
// load wait and one with a three-cycle wait, sharing the request bus.
module tb_mem_access_unit;
  import mips_mem_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        req_valid1, req_valid3;
  logic [2:0]  req_op;
  logic [31:0] req_base;
  logic [15:0] req_offset;
  logic [31:0] req_wdata;
  logic        flush;
  logic [31:0] ram_rdata;

  logic        rdy1, rv1, exc1, we1, sx1;
  logic [31:0] rd1, bad1, addr1, wd1;
  logic [4:0]  code1;
  logic [1:0]  mask1;

  logic        rdy3, rv3, exc3, we3, sx3;
  logic [31:0] rd3, bad3, addr3, wd3;
  logic [4:0]  code3;
  logic [1:0]  mask3;

  int n_chk  = 0;
  int n_fail = 0;

  mem_access_unit #(.WAIT_CYCLES(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid1), .req_ready(rdy1), .req_op(req_op),
    .req_base(req_base), .req_offset(req_offset), .req_wdata(req_wdata),
    .flush(flush),
    .resp_valid(rv1), .resp_rdata(rd1), .resp_exc(exc1),
    .resp_exc_code(code1), .resp_badvaddr(bad1),
    .ram_we(we1), .ram_addr(addr1), .ram_mask(mask1),
    .ram_signed_ext(sx1), .ram_wdata(wd1), .ram_rdata(ram_rdata)
  );

  mem_access_unit #(.WAIT_CYCLES(3)) dut3 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid3), .req_ready(rdy3), .req_op(req_op),
    .req_base(req_base), .req_offset(req_offset), .req_wdata(req_wdata),
    .flush(flush),
    .resp_valid(rv3), .resp_rdata(rd3), .resp_exc(exc3),
    .resp_exc_code(code3), .resp_badvaddr(bad3),
    .ram_we(we3), .ram_addr(addr3), .ram_mask(mask3),
    .ram_signed_ext(sx3), .ram_wdata(wd3), .ram_rdata(ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic [2:0] op, input logic [31:0] base,
                         input logic [15:0] off, input logic [31:0] wd);
    req_op     = op;
    req_base   = base;
    req_offset = off;
    req_wdata  = wd;
  endtask

  initial begin
    int cyc;
    rst_n = 1'b0;
    req_valid1 = 1'b0;
    req_valid3 = 1'b0;
    flush = 1'b0;
    ram_rdata = 32'd0;
    set_req(3'd0, 32'd0, 16'd0, 32'd0);
    #3;
    chk("rst_ready",  {31'd0, rdy1}, 32'd1);
    chk("rst_valid",  {31'd0, rv1},  32'd0);
    chk("rst_we",     {31'd0, we1},  32'd0);
    chk("rst_rdata",  rd1,           32'd0);
    chk("rst_addr",   addr1,         32'd0);
    chk("rst_sext",   {31'd0, sx1},  32'd0);
    chk("rst_code",   {27'd0, code1}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    step();

    // SW base 0x100 + 4
    set_req(MEM_SW, 32'h100, 16'h0004, 32'hDEADBEEF);
    req_valid1 = 1'b1;
    chk("sw_idle_we", {31'd0, we1}, 32'd0);
    step();
    req_valid1 = 1'b0;
    chk("sw_acc_we",    {31'd0, we1},   32'd1);
    chk("sw_acc_addr",  addr1,          32'h104);
    chk("sw_acc_mask",  {30'd0, mask1}, 32'd2);
    chk("sw_acc_wdata", wd1,            32'hDEADBEEF);
    chk("sw_acc_rv",    {31'd0, rv1},   32'd0);
    chk("sw_acc_ready", {31'd0, rdy1},  32'd0);
    step();
    chk("sw_done_rv",  {31'd0, rv1},  32'd1);
    chk("sw_done_exc", {31'd0, exc1}, 32'd0);
    chk("sw_done_we",  {31'd0, we1},  32'd0);
    step();
    chk("sw_idle_rv",    {31'd0, rv1},  32'd0);
    chk("sw_idle_ready", {31'd0, rdy1}, 32'd1);

    // LB ea 0x103, sign-extending
    set_req(MEM_LB, 32'h104, 16'hFFFF, 32'h0);
    ram_rdata = 32'hFFFFFFDE;
    req_valid1 = 1'b1;
    step();
    req_valid1 = 1'b0;
    chk("lb_addr", addr1,          32'h103);
    chk("lb_mask", {30'd0, mask1}, 32'd0);
    chk("lb_sext", {31'd0, sx1},   32'd1);
    chk("lb_we",   {31'd0, we1},   32'd0);
    step();
    chk("lb_rv",    {31'd0, rv1}, 32'd1);
    chk("lb_rdata", rd1,          32'hFFFFFFDE);
    step();

    // LBU same address, zero-extending
    set_req(MEM_LBU, 32'h104, 16'hFFFF, 32'h0);
    ram_rdata = 32'h0000005A;
    req_valid1 = 1'b1;
    step();
    req_valid1 = 1'b0;
    chk("lbu_sext", {31'd0, sx1}, 32'd0);
    step();
    chk("lbu_rv",    {31'd0, rv1}, 32'd1);
    chk("lbu_rdata", rd1,          32'h5A);
    step();

    // LH misaligned -> AdEL
    set_req(MEM_LH, 32'h100, 16'h0001, 32'h0);
    req_valid1 = 1'b1;
    step();
    req_valid1 = 1'b0;
    chk("lh_exc_rv",   {31'd0, rv1},   32'd1);
    chk("lh_exc_flag", {31'd0, exc1},  32'd1);
    chk("lh_exc_code", {27'd0, code1}, 32'd4);
    chk("lh_exc_bad",  bad1,           32'h101);
    chk("lh_exc_we",   {31'd0, we1},   32'd0);
    chk("lh_exc_addr", addr1,          32'h103);
    step();
    chk("lh_post_rv",   {31'd0, rv1},   32'd0);
    chk("lh_post_code", {27'd0, code1}, 32'd4);

    // SW misaligned -> AdES, no write, MDR untouched
    set_req(MEM_SW, 32'h100, 16'h0002, 32'h12345678);
    req_valid1 = 1'b1;
    step();
    req_valid1 = 1'b0;
    chk("sw_exc_we",    {31'd0, we1},   32'd0);
    chk("sw_exc_flag",  {31'd0, exc1},  32'd1);
    chk("sw_exc_code",  {27'd0, code1}, 32'd5);
    chk("sw_exc_bad",   bad1,           32'h102);
    chk("sw_exc_rdata", rd1,            32'h5A);
    step();
    chk("sw_post_we", {31'd0, we1}, 32'd0);

    // SH flushed in its ACCESS cycle
    set_req(MEM_SH, 32'h200, 16'h0010, 32'hABCD1234);
    req_valid1 = 1'b1;
    step();
    req_valid1 = 1'b0;
    flush = 1'b1;
    #1;
    chk("sh_flush_we", {31'd0, we1}, 32'd0);
    chk("sh_flush_rv", {31'd0, rv1}, 32'd0);
    step();
    flush = 1'b0;
    chk("sh_post_ready", {31'd0, rdy1}, 32'd1);
    chk("sh_post_rv",    {31'd0, rv1},  32'd0);
    chk("sh_post_we",    {31'd0, we1},  32'd0);
    chk("sh_post_rdata", rd1,           32'h5A);

    // flush in IDLE does not block an accept
    set_req(MEM_LW, 32'h300, 16'h0000, 32'h0);
    ram_rdata = 32'hCAFEF00D;
    req_valid1 = 1'b1;
    flush = 1'b1;
    step();
    req_valid1 = 1'b0;
    flush = 1'b0;
    chk("idleflush_addr", addr1,          32'h300);
    chk("idleflush_mask", {30'd0, mask1}, 32'd2);
    step();
    chk("idleflush_rv",    {31'd0, rv1}, 32'd1);
    chk("idleflush_rdata", rd1,          32'hCAFEF00D);
    step();

    // LW with three wait cycles; data changes on the last ACCESS cycle
    set_req(MEM_LW, 32'h200, 16'h0000, 32'h0);
    ram_rdata = 32'h11111111;
    req_valid3 = 1'b1;
    step();
    req_valid3 = 1'b0;
    chk("lw3_addr", addr3,        32'h200);
    chk("lw3_rv_a1", {31'd0, rv3}, 32'd0);
    step();
    chk("lw3_rv_a2", {31'd0, rv3}, 32'd0);
    step();
    ram_rdata = 32'h22222222;
    chk("lw3_rv_a3", {31'd0, rv3}, 32'd0);
    step();
    chk("lw3_rv",    {31'd0, rv3}, 32'd1);
    chk("lw3_rdata", rd3,          32'h22222222);
    step();
    chk("lw3_idle_rv", {31'd0, rv3}, 32'd0);

    // async reset in the middle of a load's ACCESS phase
    set_req(MEM_LW, 32'h400, 16'h0000, 32'h0);
    ram_rdata = 32'h33333333;
    req_valid3 = 1'b1;
    step();
    req_valid3 = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_rdata3", rd3,          32'd0);
    chk("arst_addr3",  addr3,        32'd0);
    chk("arst_rv3",    {31'd0, rv3}, 32'd0);
    chk("arst_ready3", {31'd0, rdy3}, 32'd1);
    chk("arst_rdata1", rd1,          32'd0);
    chk("arst_code1",  {27'd0, code1}, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    step();

    set_req(MEM_LW, 32'h400, 16'h0008, 32'h0);
    ram_rdata = 32'h44444444;
    req_valid3 = 1'b1;
    step();
    req_valid3 = 1'b0;
    cyc = 1;
    while (!rv3 && cyc < 10) begin
      step();
      cyc++;
    end
    chk("post_rst_latency", cyc, 32'd4);
    chk("post_rst_rv",      {31'd0, rv3}, 32'd1);
    chk("post_rst_addr",    addr3, 32'h408);
    chk("post_rst_rdata",   rd3,   32'h44444444);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Load/store sequencer directly upstream of the data RAM in the multicycle MIPS core.
- Accepts one decoded memory instruction from the control FSM and forms the effective address base + sign-extended offset.
- Checks natural alignment and raises AdEL/AdES on a misaligned access.
- Drives the RAM's we/addr/mask/signed_ext/wdata port and registers the load result as the memory data register (MDR) for write-back.

Parameters:
WAIT_CYCLES, 1, number of ACCESS cycles a load holds the address before capturing ram_rdata (legal range 1..15)
ADDR_W, 32, effective-address width

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
req_valid  in  1  control FSM presents a memory op
req_ready  out  1  unit idle, request accepted when req_valid & req_ready
req_op  in  3  0 LB, 1 LBU, 2 LH, 3 LHU, 4 LW, 5 SB, 6 SH, 7 SW
req_base  in  32  rs value
req_offset  in  16  immediate, sign-extended internally
req_wdata  in  32  rt value for stores
flush  in  1  abort in-flight op (exception/interrupt from core)
resp_valid  out  1  one-cycle completion pulse
resp_rdata  out  32  MDR; load result, held until next load completes
resp_exc  out  1  qualifies resp_valid; address error
resp_exc_code  out  5  4 = AdEL, 5 = AdES, else 0
resp_badvaddr  out  32  faulting effective address
ram_we  out  1  RAM write enable
ram_addr  out  32  RAM byte address
ram_mask  out  2  00 byte, 01 half, 10 word
ram_signed_ext  out  1  sign-extend sub-word read
ram_wdata  out  32  store data, unshifted; RAM uses low byte/half
ram_rdata  in  32  RAM combinational read data

Behaviour:
- Reset (rst_n low, async): state IDLE, all outputs and internal registers 0, except req_ready = 1 once in IDLE.
- States: IDLE, ACCESS, DONE, EXC.
- IDLE: req_ready = 1. On req_valid, register op, wdata and ea = req_base + {{16{req_offset[15]}}, req_offset}, with mod 2^32 wrap and no overflow trap.
  - Misaligned (half with ea[0] = 1; word with ea[1:0] != 0): go to EXC.
  - Otherwise: go to ACCESS, load wait counter with WAIT_CYCLES - 1.
- ACCESS: ram_addr = ea. ram_mask is derived from op; ram_signed_ext = 1 only for LB/LH.
  - Store: ram_we = 1 for exactly this one cycle, gated combinationally by !flush; next state DONE.
  - Load: counter decrements each cycle. On the cycle the counter is 0, resp_rdata <= ram_rdata and next state is DONE.
  - Load latency from the accept edge to resp_valid is WAIT_CYCLES + 1 cycles. Store latency is 2 cycles.
- DONE: resp_valid = 1, resp_exc = 0, then IDLE. resp_rdata is unchanged by stores.
- EXC: resp_valid = 1, resp_exc = 1, resp_exc_code = 4 (loads) or 5 (stores), resp_badvaddr = ea, then IDLE. No RAM write occurs.
- req_ready = 0 in ACCESS/DONE/EXC; req_valid there is ignored.
- flush in any non-IDLE state: next state IDLE, no resp_valid, counter cleared. A flushed store never asserts ram_we. flush in IDLE has no effect and a request in that same cycle is still accepted.
- ram_we = 0 outside ACCESS. ram_addr/mask/signed_ext/wdata keep their last registered values.
- resp_exc_code and resp_badvaddr hold until the next EXC.

Decomposition:
- Shared package mips_mem_pkg holds:
  - op encodings (MEM_LB..MEM_SW)
  - mask constants (MASK_BYTE = 2'b00, MASK_HALF = 2'b01, MASK_WORD = 2'b10)
  - exception codes (EXC_ADEL = 5'd4, EXC_ADES = 5'd5)
  - state encoding
- One natural combinational sub-module, mem_op_decode: op -> {is_store, mask, signed_ext} plus the alignment check on ea[1:0].

Test Plan:
- WAIT_CYCLES = 1; SW base 0x100, offset 0x0004, wdata 0xDEADBEEF -> ram_we for one cycle with ram_addr 0x104, mask 10; resp_valid 2 cycles after accept.
- LB base 0x104, offset 0xFFFF (ea 0x103), ram_rdata 0xFFFFFFDE -> ram_mask 00, signed_ext 1; resp_rdata 0xFFFFFFDE; repeat with LBU -> signed_ext 0.
- LH ea 0x101 -> no ram_we; resp_valid with resp_exc 1, code 4, badvaddr 0x101. SW ea 0x102 -> code 5, RAM untouched.
- WAIT_CYCLES = 3; LW ea 0x200, ram_rdata changed 0x11111111 -> 0x22222222 on the last ACCESS cycle -> resp_rdata 0x22222222, resp_valid 4 cycles after accept.
- SH accepted and flush asserted in the same cycle as ACCESS -> ram_we stays 0, no resp_valid, req_ready 1 the next cycle.
- rst_n dropped asynchronously mid-ACCESS of a load -> all outputs 0 immediately; first request after release completes normally.
